// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker
// Receive-side monitor for a one-hot ring counter. Decodes each qualified
// sample to a binary index, checks one-hot encoding and rotation order,
// locks onto a healthy sequence, counts laps and counts errors.
module ring_sequence_checker #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 2,
   parameter int LAP_W  = 8,
   parameter int ERR_W  = 8,
   parameter int IDX_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [IDX_W-1:0] idx,
   output logic             idx_valid,
   output logic             locked,
   output logic             lap_tick,
   output logic [LAP_W-1:0] lap_count,
   output logic             onehot_err,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_count
);

   // match counter only has to reach LOCK_N
   localparam int MC_W = $clog2(LOCK_N + 1);
   localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_N);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_CONFIRM = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;

   // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
   function automatic logic f_is_onehot(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] low_cleared;
      low_cleared = d & (d - {{(WIDTH-1){1'b0}}, 1'b1});
      return (d != {WIDTH{1'b0}}) && (low_cleared == {WIDTH{1'b0}});
   endfunction

   // next expected ring value: shift left, MSB wraps into bit 0
   function automatic logic [WIDTH-1:0] f_rot(input logic [WIDTH-1:0] d);
      return {d[WIDTH-2:0], d[WIDTH-1]};
   endfunction

   // binary position of the set bit (only meaningful for legal samples)
   function automatic logic [IDX_W-1:0] f_encode(input logic [WIDTH-1:0] d);
      logic [IDX_W-1:0] pos;
      pos = {IDX_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (d[i]) begin
            pos = IDX_W'(i);
         end else begin
            pos = pos;
         end
      end
      return pos;
   endfunction

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_ref;
   logic [MC_W-1:0]  r_match;
   logic [IDX_W-1:0] r_idx;
   logic             r_idx_valid;
   logic             r_locked;
   logic             r_lap_tick;
   logic [LAP_W-1:0] r_lap_count;
   logic             r_onehot_err;
   logic             r_seq_err;
   logic [ERR_W-1:0] r_err_count;

   logic             w_legal;
   logic             w_in_order;
   logic [MC_W-1:0]  w_match_inc;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_ref_nxt;
   logic [MC_W-1:0]  w_match_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_idx_valid;
   logic             w_lap_tick;
   logic             w_onehot_err;
   logic             w_seq_err;

   assign w_legal     = f_is_onehot(din);
   assign w_in_order  = (din == f_rot(r_ref));
   assign w_match_inc = r_match + {{(MC_W-1){1'b0}}, 1'b1};

   // next-state, reference tracking and per-sample pulse decode
   always_comb begin
      w_state_nxt  = r_state;
      w_ref_nxt    = r_ref;
      w_match_nxt  = r_match;
      w_idx_nxt    = r_idx;
      w_idx_valid  = 1'b0;
      w_lap_tick   = 1'b0;
      w_onehot_err = 1'b0;
      w_seq_err    = 1'b0;
      if (din_valid) begin
         if (w_legal) begin
            w_idx_nxt   = f_encode(din);
            w_idx_valid = 1'b1;
            case (r_state)
               S_SEARCH: begin
                  w_ref_nxt   = din;
                  w_match_nxt = {MC_W{1'b0}};
                  w_state_nxt = S_CONFIRM;
               end
               S_CONFIRM: begin
                  w_ref_nxt = din;
                  if (w_in_order) begin
                     w_match_nxt = w_match_inc;
                     if (w_match_inc == LOCK_V) begin
                        w_state_nxt = S_LOCKED;
                     end else begin
                        w_state_nxt = S_CONFIRM;
                     end
                  end else begin
                     w_match_nxt = {MC_W{1'b0}};
                  end
               end
               S_LOCKED: begin
                  w_ref_nxt = din;
                  if (w_in_order) begin
                     w_lap_tick = din[0];
                  end else begin
                     w_seq_err   = 1'b1;
                     w_match_nxt = {MC_W{1'b0}};
                     w_state_nxt = S_CONFIRM;
                  end
               end
               default: begin
                  // unreachable encoding: recover by searching again
                  w_state_nxt = S_SEARCH;
                  w_match_nxt = {MC_W{1'b0}};
               end
            endcase
         end else begin
            // not one-hot: flag it and drop any lock from every state
            w_onehot_err = 1'b1;
            w_state_nxt  = S_SEARCH;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // state and registered outputs; synchronous reset wins over din_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_SEARCH;
         r_ref        <= {WIDTH{1'b0}};
         r_match      <= {MC_W{1'b0}};
         r_idx        <= {IDX_W{1'b0}};
         r_idx_valid  <= 1'b0;
         r_locked     <= 1'b0;
         r_lap_tick   <= 1'b0;
         r_lap_count  <= {LAP_W{1'b0}};
         r_onehot_err <= 1'b0;
         r_seq_err    <= 1'b0;
         r_err_count  <= {ERR_W{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_ref        <= w_ref_nxt;
         r_match      <= w_match_nxt;
         r_idx        <= w_idx_nxt;
         r_idx_valid  <= w_idx_valid;
         r_locked     <= (w_state_nxt == S_LOCKED);
         r_lap_tick   <= w_lap_tick;
         r_onehot_err <= w_onehot_err;
         r_seq_err    <= w_seq_err;
         if (w_lap_tick) begin
            r_lap_count <= r_lap_count + {{(LAP_W-1){1'b0}}, 1'b1};
         end else begin
            r_lap_count <= r_lap_count;
         end
         if ((w_onehot_err || w_seq_err) && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
         end else begin
            r_err_count <= r_err_count;
         end
      end
   end

   assign idx        = r_idx;
   assign idx_valid  = r_idx_valid;
   assign locked     = r_locked;
   assign lap_tick   = r_lap_tick;
   assign lap_count  = r_lap_count;
   assign onehot_err = r_onehot_err;
   assign seq_err    = r_seq_err;
   assign err_count  = r_err_count;

endmodule
